stack_controller: RTL and testbench
===================================

Name: stack_controller

Overview:
- Push/pop sequencer that sits directly upstream of the data memory and drives its address, write-data and write-enable inputs.
- Consumes the memory's combinational read data.
- Gives the CPU datapath single-request push/pop operations on a descending stack held in a fixed window of data memory.
- Owns the stack pointer and reports full/empty/error status.

Parameters:
- ADDR_WIDTH, 8, memory address width and stack pointer width.
- DATA_WIDTH, 8, data word width.
- STACK_TOP, 8'hFF, SP value when the stack is empty. The highest used slot is STACK_TOP-1.
- STACK_LIMIT, 8'hF0, lowest usable slot. Full when SP==STACK_LIMIT. Capacity = STACK_TOP-STACK_LIMIT = 15. STACK_LIMIT < STACK_TOP is required.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- pushReq  input  1  request to push pushData.
- popReq  input  1  request to pop into popData.
- pushData  input  DATA_WIDTH  value to push; sampled when a push is accepted.
- ready  output  1  high in IDLE; a request is accepted only while ready=1.
- done  output  1  one-cycle pulse when an operation completes.
- error  output  1  one-cycle pulse when a request is rejected.
- popData  output  DATA_WIDTH  last popped value; held until the next pop completes.
- sp  output  ADDR_WIDTH  current stack pointer.
- depth  output  ADDR_WIDTH  STACK_TOP-sp.
- full  output  1  sp==STACK_LIMIT (combinational from sp).
- empty  output  1  sp==STACK_TOP (combinational from sp).
- memAddress  output  ADDR_WIDTH  to data memory Address.
- memWriteData  output  DATA_WIDTH  to data memory WriteData.
- memWriteEnable  output  1  to data memory writeEnable.
- memData  input  DATA_WIDTH  from data memory Data; combinational read of memAddress.

Behaviour:
- Reset (async, reset=0), applied immediately, including mid-operation:
  - state=IDLE, sp=STACK_TOP.
  - popData=0, memAddress=STACK_TOP, memWriteData=0, memWriteEnable=0.
  - done=0, error=0. Therefore ready=1, empty=1, full=0.
  - An in-flight write is abandoned: writeEnable drops asynchronously and sp is not committed.
- Registered outputs: memAddress, memWriteData, memWriteEnable, done, error, popData. Others are combinational from state/sp.
- States: IDLE, WRITE, READ.
- IDLE, at each edge:
  - pushReq=1, popReq=0, full=0: memAddress<=sp-1, memWriteData<=pushData, memWriteEnable<=1, sp<=sp-1, go to WRITE.
  - popReq=1, pushReq=0, empty=0: memAddress<=sp, memWriteEnable<=0, go to READ.
  - pushReq=1 with full=1, popReq=1 with empty=1, or pushReq=popReq=1: error<=1 for one cycle. No memory access; sp unchanged; stay in IDLE.
  - No request: hold state; done<=0, error<=0.
- WRITE (exactly 1 cycle):
  - The memory samples the write on this edge.
  - memWriteEnable<=0, done<=1, go to IDLE.
  - Push latency: accept edge to done-high is 1 cycle. ready=0 for 1 cycle.
- READ (exactly 1 cycle):
  - popData<=memData, sp<=sp+1, done<=1, go to IDLE.
  - Pop latency: 1 cycle from accept to done; popData is valid together with done.
- Requests arriving while ready=0 are ignored: no error, not queued. A request must be held or re-issued until it is accepted.
- memAddress holds its last value in IDLE. memWriteEnable is high only during WRITE.
- Arithmetic is unsigned, ADDR_WIDTH wide. sp never leaves [STACK_LIMIT, STACK_TOP] because of the full/empty checks, so no wrap-around is reachable.
- Back-to-back operations: a new request may be accepted on the edge after done, so each operation costs 2 cycles.

Test Plan:
- Reset then idle: reset=0 for 1 cycle, then release -> sp=8'hFF, empty=1, full=0, ready=1, memWriteEnable=0, done=0, error=0.
- Single push: pushData=8'h1F, pushReq for 1 cycle -> next cycle memAddress=8'hFE, memWriteData=8'h1F, memWriteEnable=1, sp=8'hFE. Following cycle done=1, memWriteEnable=0, depth=1.
- Push then pop: push 8'hA5, push 8'h3C, pop, pop -> popData=8'h3C then 8'hA5, each with a done pulse. sp returns to 8'hFF and empty=1.
- Overflow/underflow: 15 pushes -> full=1, sp=8'hF0. A 16th push -> error pulse, no memWriteEnable, sp stays 8'hF0. Pop on an empty stack -> error pulse, popData unchanged.
- Simultaneous requests: pushReq=popReq=1 in IDLE -> error=1 for 1 cycle, sp unchanged, no memory access.
- Reset mid-push: reset=0 asserted during WRITE -> memWriteEnable=0 immediately (before the next edge), sp=8'hFF, state=IDLE.

Source files
------------

// File: rtl/stack_controller.sv
// Push/pop sequencer for a descending stack held in a fixed window of data memory.
// Owns the stack pointer, drives the memory port and reports full/empty/error status.
module stack_controller #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] STACK_TOP   = 8'hFF,
  parameter logic [ADDR_WIDTH-1:0] STACK_LIMIT = 8'hF0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pushReq,
  input  logic                  popReq,
  input  logic [DATA_WIDTH-1:0] pushData,
  output logic                  ready,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] popData,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic [ADDR_WIDTH-1:0] depth,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  output logic                  memWriteEnable,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Handshake: a request is taken only on a rising edge where ready=1; requests
  // seen while ready=0 are dropped (no error, no queueing), so the requester
  // holds or re-issues until accepted. done/error each pulse for one cycle.

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   sp_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [DATA_WIDTH-1:0]   wdata_n;
  logic                    we_n;
  logic                    done_n;
  logic                    error_n;
  logic [DATA_WIDTH-1:0]   pop_n;

  assign ready     = (state == IDLE);
  assign full      = (sp == STACK_LIMIT);
  assign empty     = (sp == STACK_TOP);
  assign depth     = STACK_TOP - sp;
  assign state_dbg = state;

  // Reset also abandons an in-flight write: the enable drops asynchronously
  // and the already-decremented sp is thrown away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      sp             <= STACK_TOP;
      memAddress     <= STACK_TOP;
      memWriteData   <= '0;
      memWriteEnable <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      popData        <= '0;
    end else begin
      state          <= state_n;
      sp             <= sp_n;
      memAddress     <= addr_n;
      memWriteData   <= wdata_n;
      memWriteEnable <= we_n;
      done           <= done_n;
      error          <= error_n;
      popData        <= pop_n;
    end
  end

  always_comb begin
    state_n = state;
    sp_n    = sp;
    addr_n  = memAddress;
    wdata_n = memWriteData;
    we_n    = 1'b0;
    done_n  = 1'b0;
    error_n = 1'b0;
    pop_n   = popData;
    case (state)
      IDLE: begin
        if (pushReq && popReq) begin
          error_n = 1'b1;
        end else if (pushReq) begin
          if (full) begin
            error_n = 1'b1;
          end else begin
            // sp is committed at accept so it already names the new top.
            addr_n  = sp - ONE;
            wdata_n = pushData;
            we_n    = 1'b1;
            sp_n    = sp - ONE;
            state_n = WRITE;
          end
        end else if (popReq) begin
          if (empty) begin
            error_n = 1'b1;
          end else begin
            addr_n  = sp;
            state_n = READ;
          end
        end
      end
      WRITE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      READ: begin
        pop_n   = memData;
        sp_n    = sp + ONE;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller: memory model, reference stack model and a
// scoreboard that checks every done/error pulse against queued expectations.
module tb_stack_controller;

  localparam int W = 18; // {error, done, popData, sp}

  logic       clk = 1'b0;
  logic       reset;
  logic       pushReq, popReq;
  logic [7:0] pushData;
  logic       ready, done, error, full, empty, memWriteEnable;
  logic [7:0] popData, sp, depth, memAddress, memWriteData, memData;
  logic [1:0] state_dbg;

  logic [7:0] mem [256];
  logic [7:0] m_mem [256];
  logic [7:0] sp_m;
  logic [7:0] pop_m;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  stack_controller dut (
    .clk(clk), .reset(reset), .pushReq(pushReq), .popReq(popReq),
    .pushData(pushData), .ready(ready), .done(done), .error(error),
    .popData(popData), .sp(sp), .depth(depth), .full(full), .empty(empty),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memWriteEnable(memWriteEnable), .memData(memData), .state_dbg(state_dbg)
  );

  // clock / reset / memory
  always #5 clk = ~clk;

  assign memData = mem[memAddress];
  always @(posedge clk) if (memWriteEnable) mem[memAddress] <= memWriteData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b1 && (done === 1'b1 || error === 1'b1)) begin
      logic [W-1:0] act, e;
      act = {error, done, popData, sp};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse actual=%0h required=none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL response actual=%0h required=%0h", act, e);
        end
      end
    end
  end

  // driver tasks
  task automatic do_push(input logic [7:0] d);
    logic acc;
    @(negedge clk);
    pushReq = 1'b1; pushData = d;
    acc = (sp_m != 8'hF0);
    if (acc) begin
      sp_m = sp_m - 8'd1;
      m_mem[sp_m] = d;
      exp_q.push_back({2'b01, pop_m, sp_m});
    end else begin
      exp_q.push_back({2'b10, pop_m, sp_m});
    end
    @(negedge clk);
    pushReq = 1'b0;
    if (acc) begin
      check("push_we", {31'd0, memWriteEnable}, 32'd1);
      check("push_addr", {24'd0, memAddress}, {24'd0, sp_m});
      check("push_wdata", {24'd0, memWriteData}, {24'd0, d});
      check("push_busy", {31'd0, ready}, 32'd0);
    end else begin
      check("rej_push_we", {31'd0, memWriteEnable}, 32'd0);
      check("rej_push_sp", {24'd0, sp}, {24'd0, sp_m});
    end
    @(negedge clk);
    check("after_push_we", {31'd0, memWriteEnable}, 32'd0);
    check("depth", {24'd0, depth}, {24'd0, 8'hFF - sp_m});
  endtask

  task automatic do_pop();
    @(negedge clk);
    popReq = 1'b1;
    if (sp_m != 8'hFF) begin
      pop_m = m_mem[sp_m];
      sp_m  = sp_m + 8'd1;
      exp_q.push_back({2'b01, pop_m, sp_m});
    end else begin
      exp_q.push_back({2'b10, pop_m, sp_m});
    end
    @(negedge clk);
    popReq = 1'b0;
    check("pop_we", {31'd0, memWriteEnable}, 32'd0);
    @(negedge clk);
  endtask

  task automatic do_both();
    @(negedge clk);
    pushReq = 1'b1; popReq = 1'b1; pushData = 8'h77;
    exp_q.push_back({2'b10, pop_m, sp_m});
    @(negedge clk);
    pushReq = 1'b0; popReq = 1'b0;
    check("both_we", {31'd0, memWriteEnable}, 32'd0);
    check("both_sp", {24'd0, sp}, {24'd0, sp_m});
    check("both_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; m_mem[i] = 8'h00; end
    pushReq = 1'b0; popReq = 1'b0; pushData = 8'h00;
    sp_m = 8'hFF; pop_m = 8'h00;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_sp", {24'd0, sp}, 32'hFF);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we", {31'd0, memWriteEnable}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_popdata", {24'd0, popData}, 32'd0);
    check("rst_addr", {24'd0, memAddress}, 32'hFF);

    // single push, then LIFO pair
    do_push(8'h1F);
    do_pop();
    do_push(8'hA5);
    do_push(8'h3C);
    do_pop();
    do_pop();
    check("lifo_empty", {31'd0, empty}, 32'd1);
    check("lifo_sp", {24'd0, sp}, 32'hFF);

    // underflow: popData must keep last popped value (A5)
    do_pop();
    // simultaneous requests
    do_both();

    // fill to capacity, then overflow
    for (int i = 0; i < 15; i++) do_push(8'h40 + 8'(i));
    check("full_flag", {31'd0, full}, 32'd1);
    check("full_sp", {24'd0, sp}, 32'hF0);
    do_push(8'hEE);
    do_both();
    do_pop();
    do_pop();
    check("after_pops_sp", {24'd0, sp}, 32'hF2);

    // reset mid-push: enable must drop before the next edge
    @(negedge clk);
    pushReq = 1'b1; pushData = 8'h99;
    @(posedge clk);
    #1;
    pushReq = 1'b0;
    check("midrst_we_before", {31'd0, memWriteEnable}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_we", {31'd0, memWriteEnable}, 32'd0);
    check("midrst_sp", {24'd0, sp}, 32'hFF);
    check("midrst_state", {30'd0, state_dbg}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    sp_m = 8'hFF; pop_m = 8'h00;
    for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
    do_push(8'h5A);
    do_pop();

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
